inst_fetch_unit: RTL

INST_FETCH_UNIT -- requirements
Module: inst_fetch_unit

---
 rtl/inst_fetch_unit_pkg.sv | 21 ++
 rtl/inst_fetch_unit.sv | 122 ++++++++++++
 2 files changed

// File: rtl/inst_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: bus widths, the
// default boot address, the NOP word and the fetch state encoding.
package inst_fetch_unit_pkg;

  localparam int          XLEN             = 32;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] NOP_WORD         = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_ERROR = 2'd2
  } fetch_state_t;

  // Word-aligned target check for redirects.
  function automatic logic is_aligned(input logic [XLEN-1:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: holds one instruction for IF/ID, prefetches the
// next word while holding, and traps into a sticky error state on a
// misaligned redirect. Memory is non-binding: a request completes only in a
// cycle where imem_req and imem_ready are both high.
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pc_write,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] is,
  output logic [XLEN-1:0] pc_plus4F,
  output logic            fetch_valid,
  output logic            addr_err
);

  fetch_state_t    state_reg, state_next;
  logic [XLEN-1:0] pc_reg, pc_next;
  logic [XLEN-1:0] buf_reg, buf_next;
  logic            valid_reg, valid_next;
  logic            err_reg, err_next;

  // Sequential pc + 4; wraps naturally modulo 2^32.
  logic [XLEN-1:0] pc_plus4;
  assign pc_plus4 = pc_reg + PC_STEP;

  assign is          = valid_reg ? buf_reg : NOP_WORD;
  assign fetch_valid = valid_reg;
  assign pc_plus4F   = pc_plus4;
  assign addr_err    = err_reg;

  // State and datapath registers; reset clears everything without waiting for clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_FETCH;
      pc_reg    <= RESET_PC;
      buf_reg   <= NOP_WORD;
      valid_reg <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      buf_reg   <= buf_next;
      valid_reg <= valid_next;
      err_reg   <= err_next;
    end
  end

  // Next-state, next-PC mux and memory request; redirect outranks everything
  // else, and any data returned in a redirect cycle is dropped.
  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    buf_next   = buf_reg;
    valid_next = valid_reg;
    err_next   = err_reg;
    imem_req   = 1'b1;
    imem_addr  = pc_reg;

    case (state_reg)
      ST_FETCH: begin
        imem_addr = pc_reg;
        if (redirect) begin
          valid_next = 1'b0;
          if (is_aligned(redirect_pc)) begin
            pc_next    = redirect_pc;
            state_next = ST_FETCH;
          end else begin
            err_next   = 1'b1;
            state_next = ST_ERROR;
          end
        end else if (imem_ready) begin
          buf_next   = imem_rdata;
          valid_next = 1'b1;
          state_next = ST_HOLD;
        end
      end

      ST_HOLD: begin
        // Prefetch the word after the one being held.
        imem_addr = pc_plus4;
        if (redirect) begin
          valid_next = 1'b0;
          if (is_aligned(redirect_pc)) begin
            pc_next    = redirect_pc;
            state_next = ST_FETCH;
          end else begin
            err_next   = 1'b1;
            state_next = ST_ERROR;
          end
        end else if (pc_write) begin
          pc_next = pc_plus4;
          if (imem_ready) begin
            buf_next = imem_rdata;
          end else begin
            valid_next = 1'b0;
            state_next = ST_FETCH;
          end
        end
      end

      ST_ERROR: begin
        imem_req   = 1'b0;
        valid_next = 1'b0;
      end

      default: begin
        state_next = ST_FETCH;
        valid_next = 1'b0;
      end
    endcase
  end

endmodule
